// File: rtl/cpu_prog_sequencer.sv
// Program sequencer feeding an 8-bit accumulator CPU: preload bytes, then stream them on start.
// Optional build macro SEQ_LOOP_EN adds a `stop` input and replays the program back-to-back.
module cpu_prog_sequencer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          start,
    input  logic [AW:0]   len,
`ifdef SEQ_LOOP_EN
    input  logic          stop,
`endif
    output logic [7:0]    cpu_in,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_OP, S_ARG, S_DONE} state_t;

    localparam logic [AW:0] MAX_LEN  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PC_ONE   = (AW+1)'(1);
    localparam logic [7:0]  PAD_BYTE = 8'h00;
    localparam logic [7:0]  PARK_OP  = 8'hB0;

    state_t      state_q;
    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] len_q;
    logic [AW:0] pc_q;
    logic [AW:0] start_len_q;
    logic        start_q;
    logic        rst_cnt_q;
    logic [7:0]  cpu_in_q;
    logic        cpu_reset_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        last_w;
    logic        finish_w;
    logic        end_w;
    logic [7:0]  rd_w;

    function automatic logic is_two_byte(input logic [7:0] op);
        case (op[7:4])
            4'h6, 4'h7, 4'h8, 4'hA, 4'hC: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    assign ld_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cpu_in    = cpu_in_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // cpu_in always holds the byte just emitted; pc points at the next byte to fetch.
    assign last_w   = (pc_q == len_q);
    assign rd_w     = mem_q[pc_q[AW-1:0]];
    assign finish_w = last_w && (((state_q == S_OP) && !is_two_byte(cpu_in_q)) ||
                                 (state_q == S_ARG));
`ifdef SEQ_LOOP_EN
    assign end_w = stop;
`else
    assign end_w = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset && ld_valid && ld_ready) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            pc_q        <= '0;
            start_len_q <= '0;
            start_q     <= 1'b0;
            rst_cnt_q   <= 1'b0;
            cpu_in_q    <= 8'h00;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // start is registered once, so RST occupies exactly two cycles before edge k+3
            start_q     <= start;
            start_len_q <= len;
            if (finish_w) begin
                if (end_w) begin
                    state_q  <= S_DONE;
                    cpu_in_q <= PARK_OP;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    state_q  <= S_OP;
                    cpu_in_q <= mem_q[0];
                    pc_q     <= PC_ONE;
                end
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_q) begin
                            if ((start_len_q != '0) && (start_len_q <= MAX_LEN)) begin
                                state_q     <= S_RST;
                                len_q       <= start_len_q;
                                pc_q        <= '0;
                                rst_cnt_q   <= 1'b0;
                                cpu_reset_q <= 1'b1;
                                cpu_in_q    <= 8'h00;
                                busy_q      <= 1'b1;
                                done_q      <= 1'b0;
                                err_q       <= 1'b0;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_RST: begin
                        if (rst_cnt_q) begin
                            state_q     <= S_OP;
                            cpu_reset_q <= 1'b0;
                            cpu_in_q    <= mem_q[0];
                            pc_q        <= PC_ONE;
                        end else begin
                            rst_cnt_q <= 1'b1;
                        end
                    end
                    S_OP: begin
                        if (!last_w) begin
                            cpu_in_q <= rd_w;
                            pc_q     <= pc_q + PC_ONE;
                            state_q  <= is_two_byte(cpu_in_q) ? S_ARG : S_OP;
                        end else begin
                            // truncated two-byte opcode: feed a pad argument
                            cpu_in_q <= PAD_BYTE;
                            err_q    <= 1'b1;
                            state_q  <= S_ARG;
                        end
                    end
                    S_ARG: begin
                        cpu_in_q <= rd_w;
                        pc_q     <= pc_q + PC_ONE;
                        state_q  <= S_OP;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// Directed bench for cpu_prog_sequencer: byte streams, padding, bad lengths, reset and loop mode.
module tb_cpu_prog_sequencer;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          start;
    logic [AW:0]   len;
`ifdef SEQ_LOOP_EN
    logic          stop;
`endif
    logic [7:0]    cpu_in;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] exp_q[$];

    cpu_prog_sequencer #(.DEPTH(32), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .start     (start),
        .len       (len),
`ifdef SEQ_LOOP_EN
        .stop      (stop),
`endif
        .cpu_in    (cpu_in),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [7:0] data);
        ld_valid = 1'b1;
        ld_addr  = AW'(addr);
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    // Pulse start and check the two RST cycles; returns just before the edge that emits mem[0].
    task automatic run(input string tag, input int n);
        start = 1'b1;
        len   = (AW+1)'(n);
        tick();
        start = 1'b0;
        len   = '0;
        tick();
        chk({tag, "_rst1"}, cpu_reset, 1);
        chk({tag, "_busy_rst"}, busy, 1);
        chk({tag, "_err_clr"}, err, 0);
        tick();
        chk({tag, "_rst2"}, cpu_reset, 1);
    endtask

    task automatic expect_stream(input string tag);
        foreach (exp_q[i]) begin
            tick();
            chk($sformatf("%s_byte%0d", tag, i), cpu_in, exp_q[i]);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1);
            chk($sformatf("%s_ndone%0d", tag, i), done, 0);
            chk($sformatf("%s_crst%0d", tag, i), cpu_reset, 0);
        end
        tick();
        chk({tag, "_park"}, cpu_in, 8'hB0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; len = '0;
`ifdef SEQ_LOOP_EN
        stop = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_cpu_in", cpu_in, 8'h00);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ld_ready", ld_ready, 1);
        reset = 1'b1;
        tick();

        // Basic run
        load(0, 8'h6F); load(1, 8'hFF); load(2, 8'h7F); load(3, 8'h01); load(4, 8'h00);
        run("basic", 5);
        exp_q = '{8'h6F, 8'hFF, 8'h7F, 8'h01, 8'h00};
        expect_stream("basic");
        chk("basic_err", err, 0);
        tick();
        chk("basic_hold", cpu_in, 8'hB0);
        chk("basic_ldrdy", ld_ready, 1);

        // Argument byte that looks like an opcode
        load(0, 8'h6F); load(1, 8'h6F); load(2, 8'hB0);
        run("argop", 3);
        exp_q = '{8'h6F, 8'h6F, 8'hB0};
        expect_stream("argop");
        chk("argop_err", err, 0);
        run("argop2", 2);
        exp_q = '{8'h6F, 8'h6F};
        expect_stream("argop2");
        chk("argop2_nopad_err", err, 0);

        // Truncated instruction gets a pad byte
        load(0, 8'h00); load(1, 8'h8F);
        run("trunc", 2);
        exp_q = '{8'h00, 8'h8F, 8'h00};
        expect_stream("trunc");
        chk("trunc_err", err, 1);
        tick(); tick();
        chk("trunc_err_sticky", err, 1);

        // Accepted start clears err; bad lengths set it without entering RST
        run("clr", 1);
        exp_q = '{8'h00};
        expect_stream("clr");
        start = 1'b1; len = '0; tick(); start = 1'b0; tick(); tick();
        chk("len0_err", err, 1);
        chk("len0_norst", cpu_reset, 0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        run("clr2", 1);
        exp_q = '{8'h00};
        expect_stream("clr2");
        start = 1'b1; len = 6'd33; tick(); start = 1'b0; tick(); tick();
        chk("len33_err", err, 1);
        chk("len33_norst", cpu_reset, 0);
        chk("len33_busy", busy, 0);

        // Writes while busy are dropped
        load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
        run("bw", 4);
        ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 8'hEE;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_stream("bw");
        ld_valid = 1'b0;
        run("bw_rb", 4);
        expect_stream("bw_rb");

        // Full-depth program
        for (int i = 0; i < 32; i++) load(i, 8'(8'h10 + i));
        run("full", 32);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(8'(8'h10 + i));
        expect_stream("full");

        // Reset mid-program, with a start pulse while busy that must be ignored
        for (int i = 0; i < 8; i++) load(i, 8'(i + 1));
        run("mid", 8);
        tick(); chk("mid_b0", cpu_in, 8'h01);
        start = 1'b1; len = 6'd2;
        tick(); chk("mid_b1", cpu_in, 8'h02);
        start = 1'b0; len = '0;
        tick(); chk("mid_b2", cpu_in, 8'h03);
        chk("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_crst", cpu_reset, 1);
        chk("mid_rst_cin", cpu_in, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ldrdy", ld_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        run("replay", 8);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_stream("replay");

        // Write and start on the same edge: run sees the new byte
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 8'h5A;
        run("wrst", 1);
        ld_valid = 1'b0;
        exp_q = '{8'h5A};
        expect_stream("wrst");

`ifdef SEQ_LOOP_EN
        load(0, 8'h20);
        stop = 1'b0;
        run("loop", 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("loop_b%0d", i), cpu_in, 8'h20);
            chk($sformatf("loop_busy%0d", i), busy, 1);
        end
        stop = 1'b1;
        tick();
        chk("loop_stop_park", cpu_in, 8'hB0);
        chk("loop_stop_done", done, 1);
        stop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cpu_prog_sequencer.md
# cpu_prog_sequencer

Program sequencer that sits directly upstream of the 8-bit accumulator CPU and drives its `in` and `reset` pins. A host preloads a byte program into the sequencer's internal memory. On `start`, the sequencer pulses the CPU reset, then streams one instruction byte per clock. It tracks the CPU's two-byte instructions so that argument bytes are never decoded as opcodes. At program end it parks the CPU on a non-destructive instruction.

## Interface
- `DEPTH`, 32, program memory depth in bytes.
- `AW`, 5, address width; DEPTH = 2**AW.
- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-low reset.
- `ld_valid`  input  1  program write strobe.
- `ld_addr`  input  AW  program write address.
- `ld_data`  input  8  program write data.
- `ld_ready`  output  1  writes accepted (high in IDLE and DONE).
- `start`  input  1  single-cycle run request.
- `len`  input  AW+1  program length in bytes, sampled with `start`.
- `cpu_in`  output  8  registered byte to the CPU `in` port.
- `cpu_reset`  output  1  registered, active-high reset to the CPU.
- `busy`  output  1  high from RST through the last streamed byte.
- `done`  output  1  high in DONE until the next accepted start.
- `err`  output  1  sticky error, cleared by an accepted start.

## Operation
- States: IDLE, RST, OP, ARG, DONE.
- **IDLE**
  - `cpu_reset`=1, `cpu_in`=8'h00.
  - `start` with 1 ≤ `len` ≤ DEPTH: latch `len`, pc=0, go to RST.
  - `start` with `len`=0 or `len`>DEPTH: ignored, `err`=1.
- **RST**
  - Holds `cpu_reset`=1 for exactly 2 cycles.
  - On exit, register `cpu_reset`=0 and `cpu_in`=mem[0] on the same edge, then enter OP.
- **OP** (current byte is an opcode)
  - Two-byte opcodes, by upper nibble: 4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1100. The next byte is an argument: go to ARG.
  - All other opcodes are single-byte: stay in OP.
- **ARG**
  - The byte is emitted verbatim, whatever its value, then return to OP.
- **Program end**
  - After the byte at pc=`len`-1 is emitted, go to DONE.
  - Truncated instruction: if that last byte is a two-byte opcode, emit one pad byte 8'h00 as its argument, set `err`, then go to DONE.
- **DONE**
  - `cpu_in`=8'hB0 (Output C) every cycle; `cpu_reset`=0, `done`=1.
  - `start` here is treated as in IDLE; the CPU is reset again.
- **Memory**
  - Writes occur when `ld_valid` && `ld_ready`; ignored otherwise, no error.
  - Memory is not cleared by `reset`.
- **Reset (async, any time, including mid-program)**
  - State=IDLE, pc=0.
  - Outputs: `cpu_in`=8'h00, `cpu_reset`=1, `busy`=0, `done`=0, `err`=0, `ld_ready`=1.
  - No write is performed while `reset` is low.

## Timing
- `start` sampled at edge k: `cpu_reset`=1 during cycles k+1..k+2.
- Edge k+3: `cpu_reset`=0, `cpu_in`=mem[0].
- Edge k+3+i: `cpu_in`=mem[i]. Throughput is one byte per clock with no bubbles, except the pad byte.
- Edge k+3+`len` (plus 1 if padded): state DONE, `cpu_in`=8'hB0, `busy`=0, `done`=1.
- Write and `start` on the same edge in IDLE/DONE: the write lands first, so the run sees the new byte.
- `start` while `busy`: ignored.
- All outputs are registered; none is combinational from inputs, except `ld_ready`, which decodes state.

## Configuration
- `SEQ_LOOP_EN`
  - Defined:
    - Adds input port `stop` (1 bit).
    - After the last byte, pc wraps to 0 and the program replays back-to-back, without re-resetting the CPU.
    - The wrap is seamless: mem[len-1] at edge n, mem[0] at edge n+1.
    - `stop` high is sampled at a wrap boundary; the sequencer then enters DONE instead of wrapping.
    - A truncated last instruction still pads with 8'h00 before wrapping.
  - Undefined:
    - No `stop` port; each run ends in DONE.

## Test plan
- **Basic run.** Load {8'h6F, 8'hFF, 8'h7F, 8'h01, 8'h00}, `len`=5, pulse `start`.
  - `cpu_reset` high for 2 cycles.
  - Then `cpu_in` = 6F, FF, 7F, 01, 00 on consecutive edges, then B0 with `done`=1.
  - A CPU model ends with C=8'h00 (FF+01).
- **Argument that looks like an opcode.** Program {8'h6F, 8'h6F, 8'hB0}, `len`=3.
  - The second 8'h6F is streamed as an ARG; state returns to OP.
  - Exactly 3 bytes, then DONE.
- **Truncated instruction.** Program {8'h00, 8'h8F}, `len`=2.
  - Stream is 00, 8F, 00 (pad), then B0.
  - `err`=1 remains until the next `start`.
- **Bad length / busy writes.**
  - `len`=0: no RST entry, `err`=1.
  - `len`=33: same, `err`=1.
  - `ld_valid` while `busy`: memory is unchanged on readback.
- **Reset mid-program.** Drop `reset` at byte 3 of 8.
  - Immediately: `cpu_reset`=1, `cpu_in`=00, `busy`=0.
  - A re-`start` replays from mem[0] with memory intact.
- **Loop mode** (`SEQ_LOOP_EN`). Program {8'h20}, `len`=1.
  - Stream is 8'h20 every cycle.
  - Assert `stop`: next edge gives B0 and `done`=1.
